// File: rtl/serial_seq_controller.sv
// ---------------------------------------------------------------------------
// serial_seq_controller
//
// Purpose:
//   Sequences a bit-serial datapath through N_BITS shift-enable cycles per
//   operation. It supports single-shot and continuous (auto-restart) modes,
//   pause (hold), restart (load) and cancel (abort).
//
// Ports:
//   i_clk      - single clock; all state updates on the rising edge
//   i_reset    - asynchronous, active-low reset
//   i_load     - operation request; restarts the sequence if already running
//   i_hold     - pause; freezes the sequence while high
//   i_abort    - cancel the current operation without a done pulse
//   i_mode     - 0 = single-shot, 1 = continuous
//   o_shift_en - datapath shift/step enable
//   o_first    - shift_en cycle with count == 0
//   o_last     - shift_en cycle with count == N_BITS-1
//   o_count    - current bit index
//   o_busy     - high while the FSM is in RUN
//   o_done     - registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module serial_seq_controller #(
    parameter int N_BITS = 8,
    parameter int CNT_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_hold,
    input  logic             i_abort,
    input  logic             i_mode,
    output logic             o_shift_en,
    output logic             o_first,
    output logic             o_last,
    output logic [CNT_W-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BITS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_shift_en;

    // State register: FSM state, bit counter and the registered done pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic. Priority: abort > load > hold > advance.
    // done defaults low, so a restart or abort never produces a pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if (i_load) begin
            w_state_nxt = S_RUN;
            w_count_nxt = '0;
        end else if (w_shift_en) begin
            if (r_count == LAST_IDX) begin
                // mode is only looked at here, on the final step of a pass;
                // in continuous mode the count wraps with no gap cycle.
                w_state_nxt = i_mode ? S_RUN : S_IDLE;
                w_count_nxt = '0;
                w_done_nxt  = 1'b1;
            end else begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end
    end

    // Output logic: shift_en depends combinationally on hold so a pause
    // takes effect in the same cycle it is raised.
    always_comb begin
        o_busy     = (r_state == S_RUN);
        w_shift_en = (r_state == S_RUN) && !i_hold;
        o_shift_en = w_shift_en;
        o_first    = w_shift_en && (r_count == '0);
        o_last     = w_shift_en && (r_count == LAST_IDX);
        o_count    = r_count;
        o_done     = r_done;
    end

endmodule

// File: tb/tb_serial_seq_controller.sv
// ---------------------------------------------------------------------------
// tb_serial_seq_controller
//
// Directed testbench for serial_seq_controller (N_BITS=8, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// further time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_serial_seq_controller;

    logic       clk;
    logic       reset;
    logic       load;
    logic       hold;
    logic       abort;
    logic       mode;
    logic       shift_en;
    logic       first;
    logic       last;
    logic [3:0] count;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Observation vector: {busy, shift_en, first, last, done, count}
    logic [8:0] obs;
    logic [8:0] want;
    assign obs = {busy, shift_en, first, last, done, count};

    serial_seq_controller #(
        .N_BITS(8),
        .CNT_W (4)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_load    (load),
        .i_hold    (hold),
        .i_abort   (abort),
        .i_mode    (mode),
        .o_shift_en(shift_en),
        .o_first   (first),
        .o_last    (last),
        .o_count   (count),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ev(input logic b, input logic s, input logic f,
                                      input logic l, input logic d, input int c);
        return {b, s, f, l, d, 4'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        load  = 1'b1;
        hold  = 1'b0;
        abort = 1'b0;
        mode  = 1'b0;
        #3;
        want = ev(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", obs, want);
        end
        tick();
        tick();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_held_load: got %b want %b", obs, want);
        end
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        tick();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want %b", obs, want);
        end
    endtask

    // Single-shot pass: 8 shift cycles, then one done with busy low.
    task automatic test_basic();
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            want = ev(1, 1, i == 0, i == 7, 0, i);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL basic_run[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
        want = ev(0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL basic_done: got %b want %b", obs, want);
        end
        tick();
        want = ev(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL basic_done_single: got %b want %b", obs, want);
        end
    endtask

    // Two hold cycles at count 3: 10 busy cycles, one done.
    task automatic test_hold();
        int cnt_tab [10] = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7};
        int busy_cycles = 0;
        int done_pulses = 0;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int j = 0; j < 12; j++) begin
            hold = (j == 3 || j == 4);
            #1;
            if (busy) busy_cycles++;
            if (done) done_pulses++;
            if (j < 10) begin
                want = ev(1, !hold, (cnt_tab[j] == 0) && !hold,
                          (cnt_tab[j] == 7) && !hold, 0, cnt_tab[j]);
            end else begin
                want = ev(0, 0, 0, 0, j == 10, 0);
            end
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL hold_run[%0d]: got %b want %b", j, obs, want);
            end
            tick();
        end
        hold = 1'b0;
        checks++;
        if (busy_cycles !== 10) begin
            errors++;
            $display("FAIL hold_busy_cycles: got %0d want 10", busy_cycles);
        end
        checks++;
        if (done_pulses !== 1) begin
            errors++;
            $display("FAIL hold_done_pulses: got %0d want 1", done_pulses);
        end
    endtask

    // Continuous mode: no gap at wrap, done every 8 cycles. A mode glitch
    // away from count 7 is ignored; mode=0 at the final step ends the run.
    task automatic test_continuous();
        int done_pulses = 0;
        mode = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 10) mode = 1'b0;
            if (i == 13) mode = 1'b1;
            if (i == 26) mode = 1'b0;
            #1;
            if (done) done_pulses++;
            want = ev(1, 1, (i % 8) == 0, (i % 8) == 7,
                      (i == 8 || i == 16 || i == 24), i % 8);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL cont_run[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
        want = ev(0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL cont_end: got %b want %b", obs, want);
        end
        checks++;
        if (done_pulses !== 3) begin
            errors++;
            $display("FAIL cont_done_pulses: got %0d want 3", done_pulses);
        end
        tick();
    endtask

    // load at count 4 restarts; only the final pass produces done.
    task automatic test_back_to_back();
        int done_pulses = 0;
        int shifts = 0;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 15; k++) begin
            load = (k == 4);
            #1;
            if (done) done_pulses++;
            if (shift_en) shifts++;
            if (k == 5) begin
                want = ev(1, 1, 1, 0, 0, 0);
                checks++;
                if (obs !== want) begin
                    errors++;
                    $display("FAIL restart_count0: got %b want %b", obs, want);
                end
            end
            tick();
        end
        load = 1'b0;
        checks++;
        if (shifts !== 13) begin
            errors++;
            $display("FAIL restart_shifts: got %0d want 13", shifts);
        end
        checks++;
        if (done_pulses !== 1) begin
            errors++;
            $display("FAIL restart_done_pulses: got %0d want 1", done_pulses);
        end
    endtask

    // abort wins over load at count 6; no done afterwards.
    task automatic test_abort();
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        want = ev(1, 1, 0, 0, 0, 6);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL abort_pre: got %b want %b", obs, want);
        end
        abort = 1'b1;
        load  = 1'b1;
        tick();
        abort = 1'b0;
        load  = 1'b0;
        #1;
        want = ev(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL abort_idle: got %b want %b", obs, want);
        end
        tick();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL abort_no_done: got %b want %b", obs, want);
        end
    endtask

    // IDLE ignores hold/mode; load under hold enters RUN without shifting.
    task automatic test_idle_hold_load();
        hold = 1'b1;
        mode = 1'b1;
        tick();
        want = ev(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL idle_ignore: got %b want %b", obs, want);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        want = ev(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL load_hold_wait: got %b want %b", obs, want);
        end
        hold = 1'b0;
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            want = ev(1, 1, i == 0, i == 7, 0, i);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL load_hold_run[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
        want = ev(0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL load_hold_done: got %b want %b", obs, want);
        end
        tick();
    endtask

    // Reset between edges at count 5 clears outputs immediately.
    task automatic test_async_reset();
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        want = ev(1, 1, 0, 0, 0, 5);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL areset_pre: got %b want %b", obs, want);
        end
        #2;
        reset = 1'b0;
        #1;
        want = ev(0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL areset_immediate: got %b want %b", obs, want);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL areset_stay_idle[%0d]: got %b want %b", k, obs, want);
            end
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        #1;
        want = ev(1, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL areset_reload: got %b want %b", obs, want);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_continuous();
        test_back_to_back();
        test_abort();
        test_idle_hold_load();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_seq_controller.md
SERIAL_SEQ_CONTROLLER -- requirements
Module: serial_seq_controller

Interface
REQ-001 Parameter N_BITS, default 8: shift-enable cycles per operation; legal range 2..255.
REQ-002 Parameter CNT_W, default 4: counter width; SHALL satisfy 2^CNT_W > N_BITS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  operation request; restarts the sequence if already running.
REQ-006 hold  input  1  pause; freezes the sequence while high.
REQ-007 abort  input  1  cancel the current operation without completion.
REQ-008 mode  input  1  0 = single-shot, 1 = continuous (auto-restart).
REQ-009 shift_en  output  1  datapath shift/step enable.
REQ-010 first  output  1  high on the shift_en cycle with count = 0 (datapath clears carry/accumulator).
REQ-011 last  output  1  high on the shift_en cycle with count = N_BITS-1.
REQ-012 count  output  CNT_W  current bit index.
REQ-013 busy  output  1  high while state = RUN.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have two states, IDLE and RUN, held in a register; busy = (state == RUN).
REQ-016 The block SHALL drive shift_en combinationally as (state == RUN) && !hold.
REQ-017 The block SHALL drive first as shift_en && (count == 0), and last as shift_en && (count == N_BITS-1).
REQ-018 Synchronous priority SHALL be abort > load > hold > normal advance.
REQ-019 abort=1: next state IDLE, count = 0, done = 0, in any state.
REQ-020 load=1 with abort=0, from IDLE or RUN: next state RUN, count = 0, done = 0; no done is issued for a restarted operation.
REQ-021 RUN with hold=1 and no abort/load: state, count and done SHALL hold; done SHALL be 0.
REQ-022 RUN with shift_en=1 and count < N_BITS-1: count SHALL increment by 1.
REQ-023 RUN with shift_en=1, count = N_BITS-1, mode=0: next state IDLE, count = 0, done = 1 for exactly the following cycle.
REQ-024 RUN with shift_en=1, count = N_BITS-1, mode=1: stay in RUN, count wraps to 0, done = 1 for the following cycle, and shift_en SHALL continue with no gap cycle.
REQ-025 mode SHALL be sampled only at the count = N_BITS-1 step; changes at other times SHALL have no effect until then.
REQ-026 done SHALL be a registered output, never high for two consecutive cycles in mode 0.
REQ-027 IDLE with load=0: all outputs SHALL hold 0; hold and mode are ignored.
REQ-028 load in IDLE with hold=1: enter RUN; shift_en stays low until hold falls, then count starts at 0.
REQ-029 count SHALL never exceed N_BITS-1.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for clk, force: state IDLE, count = 0, done = 0, and therefore shift_en = first = last = busy = 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no done pulse; the first rising edge after reset deasserts SHALL sample load normally.

Verification (N_BITS=8, CNT_W=4)
REQ-032 load pulse in IDLE, mode=0, hold=0 -> shift_en high exactly 8 cycles, count 0..7, first with 0, last with 7, then done=1 for one cycle with busy=0.
REQ-033 hold=1 for 2 cycles at count=3 -> shift_en low for those 2 cycles, count stays 3, busy for 10 cycles total, one done pulse.
REQ-034 mode=1, load once, run 24 shift cycles -> count wraps 7->0 with no gap, 3 done pulses 8 cycles apart, busy stays 1.
REQ-035 load re-asserted at count=4 -> count=0 next cycle, 8 further shift cycles, exactly one done pulse overall.
REQ-036 abort and load both high at count=6 -> IDLE, count=0, no done pulse.
REQ-037 reset driven low between clock edges at count=5 -> outputs go to 0 before the next edge; after release with load=0, the block stays IDLE.
